// File: rtl/id_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcode constants,
// op-class and immediate-format enums, the decoded bundle and pure decode helpers.
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // LUI is code 0 so a cleared bundle register reads back as all zeros.
    typedef enum logic [3:0] {
        OC_LUI     = 4'd0,
        OC_AUIPC   = 4'd1,
        OC_JAL     = 4'd2,
        OC_JALR    = 4'd3,
        OC_BRANCH  = 4'd4,
        OC_LOAD    = 4'd5,
        OC_STORE   = 4'd6,
        OC_OPIMM   = 4'd7,
        OC_OP      = 4'd8,
        OC_SYSTEM  = 4'd9,
        OC_FENCE   = 4'd10,
        OC_ILLEGAL = 4'd15
    } opclass_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        opclass_t    opclass;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        rd_we;
        logic        illegal;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [31:0] imm;
    } decoded_t;

    // Immediate format implied by the opcode; R-type and unknown opcodes carry none.
    function automatic imm_fmt_t id_fmt(input logic [6:0] opcode);
        imm_fmt_t f;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                     f = IMM_U;
            OPC_JAL:                                f = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM,
            OPC_SYSTEM, OPC_FENCE:                  f = IMM_I;
            OPC_BRANCH:                             f = IMM_B;
            OPC_STORE:                              f = IMM_S;
            default:                                f = IMM_NONE;
        endcase
        return f;
    endfunction

    // 32-bit sign-extended immediate for the given format.
    function automatic logic [31:0] id_imm(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

    // Full decode of one instruction word into the execute bundle fields.
    function automatic decoded_t id_decode(input logic [31:0] instr);
        decoded_t d;
        d          = '0;
        d.opclass  = OC_ILLEGAL;
        d.funct3   = instr[14:12];
        d.funct7b5 = instr[30];
        d.rd       = instr[11:7];
        case (instr[6:0])
            OPC_LUI:    begin d.opclass = OC_LUI;    d.rd_we = 1'b1; end
            OPC_AUIPC:  begin d.opclass = OC_AUIPC;  d.rd_we = 1'b1; end
            OPC_JAL:    begin d.opclass = OC_JAL;    d.rd_we = 1'b1; end
            OPC_JALR:   begin d.opclass = OC_JALR;   d.uses_rs1 = 1'b1; d.rd_we = 1'b1; end
            OPC_BRANCH: begin d.opclass = OC_BRANCH; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OPC_LOAD:   begin d.opclass = OC_LOAD;   d.uses_rs1 = 1'b1; d.rd_we = 1'b1; end
            OPC_STORE:  begin d.opclass = OC_STORE;  d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OPC_OPIMM:  begin d.opclass = OC_OPIMM;  d.uses_rs1 = 1'b1; d.rd_we = 1'b1; end
            OPC_OP:     begin d.opclass = OC_OP;     d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.rd_we = 1'b1; end
            OPC_SYSTEM: d.opclass = OC_SYSTEM;
            OPC_FENCE:  d.opclass = OC_FENCE;
            default:    d.illegal = 1'b1;
        endcase
        d.imm = id_imm(instr, id_fmt(instr[6:0]));
        return d;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy scoreboard of in-flight destination registers with the RAW hazard check.
module id_scoreboard
    import id_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             uses_rs1,
    input  logic             uses_rs2,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             set_valid,
    input  logic [4:0]       set_rd,
    output logic             hazard,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    // Hazard looks at the registered busy bits, so a retiring register only
    // unblocks the following cycle.
    assign hazard = (uses_rs1 && busy_reg[rs1] && (rs1 != 5'd0)) ||
                    (uses_rs2 && busy_reg[rs2] && (rs2 != 5'd0));

    // Per-bit update: writeback clears, a new issue sets, and the set wins.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_bit
            assign busy_next[gi] = (set_valid && (set_rd == 5'(gi))) ||
                                   (busy_reg[gi] && !(wb_valid && (wb_rd == 5'(gi))));
        end
    end

    // Busy vector register; reset and flush both empty it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: drives register-file selects, stalls on RAW hazards
// against the busy scoreboard and registers the decoded bundle for execute.
module id_stage
    import id_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [WIDTH-1:0] if_pc,
    output logic [4:0]       rs1_select,
    output logic [4:0]       rs2_select,
    output logic [4:0]       rd_select,
    output logic             r_enable,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_imm,
    output logic [3:0]       ex_opclass,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [4:0]       ex_rd,
    output logic             ex_rd_we,
    output logic             ex_illegal,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush
);

    decoded_t         dec;
    logic             hazard;
    logic             fire;
    logic [NREGS-1:0] busy;
    logic [WIDTH-1:0] imm_ext;

    logic             ex_valid_reg;
    logic [WIDTH-1:0] ex_pc_reg;
    logic [WIDTH-1:0] ex_imm_reg;
    opclass_t         ex_opclass_reg;
    logic [2:0]       ex_funct3_reg;
    logic             ex_funct7b5_reg;
    logic [4:0]       ex_rd_reg;
    logic             ex_rd_we_reg;
    logic             ex_illegal_reg;

    assign dec = id_decode(if_instr);

    // Widen the 32-bit decoded immediate to the datapath width.
    if (WIDTH > 32) begin : g_imm_wide
        assign imm_ext = {{(WIDTH-32){dec.imm[31]}}, dec.imm};
    end else begin : g_imm_narrow
        assign imm_ext = dec.imm[WIDTH-1:0];
    end

    // Selects go straight to the register file, which samples them on the
    // same edge that loads the bundle below.
    assign rs1_select = if_instr[19:15];
    assign rs2_select = if_instr[24:20];
    assign rd_select  = if_instr[11:7];

    assign if_ready = !hazard && !flush && (!ex_valid_reg || ex_ready);
    assign fire     = if_valid && if_ready;
    assign r_enable = fire;

    id_scoreboard #(
        .NREGS(NREGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rs1      (rs1_select),
        .rs2      (rs2_select),
        .uses_rs1 (dec.uses_rs1),
        .uses_rs2 (dec.uses_rs2),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .set_valid(fire && dec.rd_we),
        .set_rd   (dec.rd),
        .hazard   (hazard),
        .busy     (busy)
    );

    // Bundle register: load on fire, drain when execute accepts, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg    <= 1'b0;
            ex_pc_reg       <= '0;
            ex_imm_reg      <= '0;
            ex_opclass_reg  <= OC_LUI;
            ex_funct3_reg   <= '0;
            ex_funct7b5_reg <= 1'b0;
            ex_rd_reg       <= '0;
            ex_rd_we_reg    <= 1'b0;
            ex_illegal_reg  <= 1'b0;
        end else if (flush) begin
            ex_valid_reg <= 1'b0;
        end else if (fire) begin
            ex_valid_reg    <= 1'b1;
            ex_pc_reg       <= if_pc;
            ex_imm_reg      <= imm_ext;
            ex_opclass_reg  <= dec.opclass;
            ex_funct3_reg   <= dec.funct3;
            ex_funct7b5_reg <= dec.funct7b5;
            ex_rd_reg       <= dec.rd;
            ex_rd_we_reg    <= dec.rd_we;
            ex_illegal_reg  <= dec.illegal;
        end else if (ex_ready) begin
            ex_valid_reg <= 1'b0;
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign ex_pc       = ex_pc_reg;
    assign ex_imm      = ex_imm_reg;
    assign ex_opclass  = ex_opclass_reg;
    assign ex_funct3   = ex_funct3_reg;
    assign ex_funct7b5 = ex_funct7b5_reg;
    assign ex_rd       = ex_rd_reg;
    assign ex_rd_we    = ex_rd_we_reg;
    assign ex_illegal  = ex_illegal_reg;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with hand-computed expected values.
module tb_id_stage;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rs1_select;
    logic [4:0]  rs2_select;
    logic [4:0]  rd_select;
    logic        r_enable;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [3:0]  ex_opclass;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        ex_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_stage #(.WIDTH(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rs1_select(rs1_select), .rs2_select(rs2_select), .rd_select(rd_select), .r_enable(r_enable),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_opclass(ex_opclass), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
        ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
        settle();
        check_val("reset ex_valid", 32'(ex_valid), 32'd0);
        check_val("reset ex_imm", ex_imm, 32'h0);
        check_val("reset ex_rd", 32'(ex_rd), 32'd0);
        check_val("reset busy", dut.busy, 32'h0);
        check_val("reset if_ready", 32'(if_ready), 32'd1);

        // addi x5,x0,7
        if_valid = 1'b1; if_instr = 32'h00700293; if_pc = 32'h100;
        settle();
        check_val("addi rs1_select", 32'(rs1_select), 32'd0);
        check_val("addi rd_select", 32'(rd_select), 32'd5);
        check_val("addi r_enable", 32'(r_enable), 32'd1);
        step();
        // add x6,x5,x5 presented while x5 busy
        if_instr = 32'h00528333; if_pc = 32'h104;
        settle();
        check_val("addi ex_valid", 32'(ex_valid), 32'd1);
        check_val("addi ex_imm", ex_imm, 32'd7);
        check_val("addi ex_rd", 32'(ex_rd), 32'd5);
        check_val("addi ex_rd_we", 32'(ex_rd_we), 32'd1);
        check_val("addi ex_opclass", 32'(ex_opclass), 32'(OC_OPIMM));
        check_val("addi ex_pc", ex_pc, 32'h100);
        check_val("addi busy", dut.busy, 32'h20);
        check_val("add hazard if_ready", 32'(if_ready), 32'd0);
        check_val("add hazard r_enable", 32'(r_enable), 32'd0);
        step();
        check_val("stall ex_valid drained", 32'(ex_valid), 32'd0);
        check_val("stall if_ready", 32'(if_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        settle();
        check_val("wb same-cycle if_ready", 32'(if_ready), 32'd0);
        step();
        wb_valid = 1'b0;
        settle();
        check_val("after wb if_ready", 32'(if_ready), 32'd1);
        check_val("after wb busy", dut.busy, 32'h0);
        step();
        // sw x5,-4(x2)
        if_instr = 32'hFE512E23; if_pc = 32'h108;
        settle();
        check_val("add ex_valid", 32'(ex_valid), 32'd1);
        check_val("add ex_opclass", 32'(ex_opclass), 32'(OC_OP));
        check_val("add ex_rd", 32'(ex_rd), 32'd6);
        check_val("add ex_pc", ex_pc, 32'h104);
        check_val("add busy", dut.busy, 32'h40);
        step();
        // backpressure; next is addi x7,x0,1
        ex_ready = 1'b0; if_instr = 32'h00100393; if_pc = 32'h10C;
        settle();
        check_val("sw ex_imm", ex_imm, 32'hFFFFFFFC);
        check_val("sw ex_rd_we", 32'(ex_rd_we), 32'd0);
        check_val("sw ex_opclass", 32'(ex_opclass), 32'(OC_STORE));
        check_val("sw busy", dut.busy, 32'h40);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("hold%0d ex_valid", i), 32'(ex_valid), 32'd1);
            check_val($sformatf("hold%0d ex_imm", i), ex_imm, 32'hFFFFFFFC);
            check_val($sformatf("hold%0d ex_pc", i), ex_pc, 32'h108);
            check_val($sformatf("hold%0d if_ready", i), 32'(if_ready), 32'd0);
            check_val($sformatf("hold%0d r_enable", i), 32'(r_enable), 32'd0);
        end
        ex_ready = 1'b1;
        settle();
        check_val("release if_ready", 32'(if_ready), 32'd1);
        step();
        if_valid = 1'b0;
        settle();
        check_val("release ex_imm", ex_imm, 32'd1);
        check_val("release ex_rd", 32'(ex_rd), 32'd7);
        check_val("release ex_pc", ex_pc, 32'h10C);
        step();
        check_val("no duplicate ex_valid", 32'(ex_valid), 32'd0);
        check_val("busy x6 x7", dut.busy, 32'hC0);
        wb_valid = 1'b1; wb_rd = 5'd6;
        step();
        wb_rd = 5'd7;
        step();
        wb_valid = 1'b0;
        settle();
        check_val("busy cleared", dut.busy, 32'h0);

        // nop (rd = x0)
        if_valid = 1'b1; if_instr = 32'h00000013; if_pc = 32'h110;
        step();
        // unknown opcode 0x7F with rd=x1
        if_instr = 32'h000000FF; if_pc = 32'h114;
        settle();
        check_val("nop ex_valid", 32'(ex_valid), 32'd1);
        check_val("nop ex_rd", 32'(ex_rd), 32'd0);
        check_val("nop busy", dut.busy, 32'h0);
        step();
        // jal x1,8
        if_instr = 32'h008000EF; if_pc = 32'h118;
        settle();
        check_val("illegal ex_illegal", 32'(ex_illegal), 32'd1);
        check_val("illegal ex_rd_we", 32'(ex_rd_we), 32'd0);
        check_val("illegal ex_imm", ex_imm, 32'h0);
        check_val("illegal ex_opclass", 32'(ex_opclass), 32'(OC_ILLEGAL));
        check_val("illegal busy", dut.busy, 32'h0);
        step();
        // lui x10,0x12345
        if_instr = 32'h12345537; if_pc = 32'h11C;
        settle();
        check_val("jal ex_imm", ex_imm, 32'd8);
        check_val("jal ex_opclass", 32'(ex_opclass), 32'(OC_JAL));
        check_val("jal busy", dut.busy, 32'h2);
        step();
        if_instr = 32'h00700293; if_pc = 32'h120;
        settle();
        check_val("lui ex_imm", ex_imm, 32'h12345000);
        check_val("lui ex_rd", 32'(ex_rd), 32'd10);
        step();
        if_valid = 1'b0;
        settle();
        check_val("pre-flush busy", dut.busy, 32'h422);
        check_val("pre-flush ex_valid", 32'(ex_valid), 32'd1);

        // flush
        flush = 1'b1; if_valid = 1'b1;
        settle();
        check_val("flush if_ready", 32'(if_ready), 32'd0);
        check_val("flush r_enable", 32'(r_enable), 32'd0);
        step();
        flush = 1'b0; if_valid = 1'b0;
        settle();
        check_val("post-flush ex_valid", 32'(ex_valid), 32'd0);
        check_val("post-flush busy", dut.busy, 32'h0);
        check_val("post-flush if_ready", 32'(if_ready), 32'd1);

        // reset with a held bundle and busy x5
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00700293; if_pc = 32'h124;
        step();
        if_valid = 1'b1; rst = 1'b1; flush = 1'b1;
        settle();
        check_val("pre-rst ex_valid", 32'(ex_valid), 32'd1);
        check_val("pre-rst busy", dut.busy, 32'h20);
        step();
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        settle();
        check_val("post-rst ex_valid", 32'(ex_valid), 32'd0);
        check_val("post-rst busy", dut.busy, 32'h0);
        check_val("post-rst ex_imm", ex_imm, 32'h0);
        check_val("post-rst ex_pc", ex_pc, 32'h0);
        check_val("post-rst if_ready", 32'(if_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
